// File: rtl/booth_pp_accumulator_if.sv
// Handshake bundle between the Booth partial-product generator, the accumulator and its consumer.
// The MAC side-band (acc_clr, mac_out) exists only when BOOTH_PP_ACC_MAC_EN is defined.
interface booth_pp_accumulator_if #(
  parameter int PP_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [PP_W-1:0] pp0;
  logic [PP_W-1:0] pp1;
  logic [PP_W-1:0] pp2;
  logic [PP_W-1:0] pp3;
  logic            out_valid;
  logic            out_ready;
  logic [PP_W-1:0] P;
  logic            busy;
`ifdef BOOTH_PP_ACC_MAC_EN
  logic            acc_clr;
  logic [23:0]     mac_out;

  modport master (
    output in_valid, pp0, pp1, pp2, pp3, out_ready, acc_clr,
    input  in_ready, out_valid, P, busy, mac_out
  );
  modport slave (
    input  in_valid, pp0, pp1, pp2, pp3, out_ready, acc_clr,
    output in_ready, out_valid, P, busy, mac_out
  );
`else
  modport master (
    output in_valid, pp0, pp1, pp2, pp3, out_ready,
    input  in_ready, out_valid, P, busy
  );
  modport slave (
    input  in_valid, pp0, pp1, pp2, pp3, out_ready,
    output in_ready, out_valid, P, busy
  );
`endif
endinterface

// File: rtl/booth_pp_accumulator.sv
// Multi-cycle reduction of four radix-4 Booth partial products into a 16-bit product.
// Optional macro BOOTH_PP_ACC_MAC_EN adds a 24-bit running sum of delivered products.
module booth_pp_accumulator #(
  parameter int PP_W = 16,
  parameter int N_PP = 4
) (
  input logic                   clk,
  input logic                   rst,
  booth_pp_accumulator_if.slave bus
);

  localparam int          CNT_W    = (N_PP > 1) ? $clog2(N_PP) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PP - 1);
  localparam int          MAC_W    = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PP_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PP_W-1:0]   pp_q [N_PP];
  logic [PP_W-1:0]   pp_d [N_PP];
  logic [PP_W-1:0]   p_q, p_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [PP_W-1:0]   in_pp_s [N_PP];
  logic [PP_W-1:0]   term_s;
  logic [PP_W-1:0]   acc_sum_s;
  logic              hs_in_s;
  logic              hs_out_s;

  assign in_pp_s[0] = bus.pp0;
  assign in_pp_s[1] = bus.pp1;
  assign in_pp_s[2] = bus.pp2;
  assign in_pp_s[3] = bus.pp3;

  // Group weight 4^cnt: shifted-out bits fall off the top, giving the mod 2^PP_W sum.
  assign term_s    = pp_q[cnt_q] << {cnt_q, 1'b0};
  assign acc_sum_s = acc_q + term_s;
  assign hs_in_s   = bus.in_valid & in_ready_q;
  assign hs_out_s  = out_valid_q & bus.out_ready;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    for (int i = 0; i < N_PP; i++) begin
      pp_d[i] = pp_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (hs_in_s) begin
          for (int i = 0; i < N_PP; i++) begin
            pp_d[i] = in_pp_s[i];
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = acc_sum_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (hs_out_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      ST_ACC: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, datapath and handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_PP; i++) begin
        pp_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < N_PP; i++) begin
        pp_q[i] <= pp_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.P         = p_q;

`ifdef BOOTH_PP_ACC_MAC_EN
  logic [MAC_W-1:0] mac_q, mac_d;

  // Running sum of delivered products; a clear wins over a same-cycle handshake
  always_comb begin
    if (bus.acc_clr) begin
      mac_d = '0;
    end else if (hs_out_s) begin
      mac_d = mac_q + {{(MAC_W-PP_W){p_q[PP_W-1]}}, p_q};
    end else begin
      mac_d = mac_q;
    end
  end

  // MAC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_q <= '0;
    end else begin
      mac_q <= mac_d;
    end
  end

  assign bus.mac_out = mac_q;
`endif

endmodule
